// File: rtl/alu_writeback_ctrl.sv
// Operand/result register stage around a combinational ALU: holds A/B, sequences ops
// IDLE->EXEC->DONE, commits ALU results and C/Z flags. Optional ALU_OVF_FLAG_EN adds flag_v.
`timescale 1ns/1ps
module alu_writeback_ctrl #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    func_sel,
  input  logic          ld_a,
  input  logic          ld_b,
  input  logic [DW-1:0] ld_data,
  output logic [3:0]    alu_func_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_z,
  input  logic [DW-1:0] alu_f,
  input  logic          alu_carry,
  input  logic          alu_overflow,
  output logic          flag_c,
  output logic          flag_z,
  output logic          skip,
`ifdef ALU_OVF_FLAG_EN
  output logic          flag_v,
`endif
  output logic          done
);

  localparam int unsigned FW = 4;

  localparam logic [FW-1:0] OP_ADD  = FW'(1);
  localparam logic [FW-1:0] OP_AND  = FW'(2);
  localparam logic [FW-1:0] OP_CLA  = FW'(3);
  localparam logic [FW-1:0] OP_CLB  = FW'(4);
  localparam logic [FW-1:0] OP_CMB  = FW'(5);
  localparam logic [FW-1:0] OP_INCB = FW'(6);
  localparam logic [FW-1:0] OP_DECB = FW'(7);
  localparam logic [FW-1:0] OP_CLC  = FW'(8);
  localparam logic [FW-1:0] OP_CLZ  = FW'(9);
  localparam logic [FW-1:0] OP_INCA = FW'(10);
  localparam logic [FW-1:0] OP_SZ   = FW'(13);
  localparam logic [FW-1:0] OP_CMA  = FW'(14);
  localparam logic [FW-1:0] OP_LSH  = FW'(15);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  state_t        state, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [FW-1:0] op_q, op_d;
  logic          c_q, c_d, z_q, z_d;
  logic          skip_q, skip_d, done_q, done_d;
  logic          zn;

  assign zn = (alu_f == DW'(0));

  // Next-state, load and writeback decode
  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    c_d     = c_q;
    z_d     = z_q;
    skip_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ld_a) a_d = ld_data;
        if (ld_b) b_d = ld_data;
        if (op_valid) begin
          op_d    = func_sel;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        skip_d  = (op_q == OP_SZ) && z_q;
        case (op_q)
          OP_ADD, OP_INCA, OP_LSH: begin
            a_d = alu_f; c_d = alu_carry; z_d = zn;
          end
          OP_AND, OP_CMA: begin
            a_d = alu_f; z_d = zn;
          end
          OP_CLA: begin
            a_d = '0; z_d = 1'b1;
          end
          OP_CLB: begin
            b_d = '0; z_d = 1'b1;
          end
          OP_INCB, OP_DECB: begin
            b_d = alu_f; c_d = alu_carry; z_d = zn;
          end
          OP_CMB: begin
            b_d = alu_f; z_d = zn;
          end
          OP_CLC:  c_d = 1'b0;
          OP_CLZ:  z_d = 1'b0;
          default: ;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      skip_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      c_q    <= c_d;
      z_q    <= z_d;
      skip_q <= skip_d;
      done_q <= done_d;
    end
  end

`ifdef ALU_OVF_FLAG_EN
  // Overflow tracks only the arithmetic ops; CLC clears it alongside C
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_v <= 1'b0;
    end else if (state == ST_EXEC) begin
      case (op_q)
        OP_ADD, OP_INCA, OP_INCB, OP_DECB, OP_LSH: flag_v <= alu_overflow;
        OP_CLC:  flag_v <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow;
`endif

  assign op_ready     = (state == ST_IDLE);
  assign alu_func_sel = (state == ST_EXEC) ? op_q : FW'(0);
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_z        = z_q;
  assign flag_c       = c_q;
  assign flag_z       = z_q;
  assign skip         = skip_q;
  assign done         = done_q;

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Directed bench for alu_writeback_ctrl with a behavioural ALU closing the loop.
`timescale 1ns/1ps
module tb_alu_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst, op_valid, op_ready, ld_a, ld_b;
  logic [3:0]  func_sel, alu_func_sel;
  logic [15:0] ld_data, alu_a, alu_b, alu_f;
  logic        alu_z, alu_carry, alu_overflow, flag_c, flag_z, skip, done;
`ifdef ALU_OVF_FLAG_EN
  logic        flag_v;
`endif

  int vectors = 0;
  int miscompares = 0;
  int dn, rd;

  always #5 clk = ~clk;

  alu_writeback_ctrl #(.DW(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .func_sel(func_sel), .ld_a(ld_a), .ld_b(ld_b), .ld_data(ld_data),
    .alu_func_sel(alu_func_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
    .alu_f(alu_f), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .flag_c(flag_c), .flag_z(flag_z), .skip(skip),
`ifdef ALU_OVF_FLAG_EN
    .flag_v(flag_v),
`endif
    .done(done)
  );

  // Reference combinational ALU
  always_comb begin
    alu_f = 16'h0000;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    case (alu_func_sel)
      4'd1: begin
        {alu_carry, alu_f} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[15] == alu_b[15]) && (alu_f[15] != alu_a[15]);
      end
      4'd2: alu_f = alu_a & alu_b;
      4'd5: alu_f = ~alu_b;
      4'd6: begin
        {alu_carry, alu_f} = {1'b0, alu_b} + 17'd1;
        alu_overflow = (alu_b == 16'h7FFF);
      end
      4'd7: begin
        alu_f = alu_b - 16'd1;
        alu_carry = (alu_b == 16'h0000);
        alu_overflow = (alu_b == 16'h8000);
      end
      4'd10: begin
        {alu_carry, alu_f} = {1'b0, alu_a} + 17'd1;
        alu_overflow = (alu_a == 16'h7FFF);
      end
      4'd14: alu_f = ~alu_a;
      4'd15: begin
        alu_f = {alu_a[14:0], 1'b0};
        alu_carry = alu_a[15];
        alu_overflow = alu_a[15] ^ alu_a[14];
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic la, input logic lb, input logic [15:0] d);
    ld_a = la; ld_b = lb; ld_data = d;
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE
  task automatic do_op(input logic [3:0] code, input logic exp_skip);
    op_valid = 1'b1; func_sel = code;
    @(negedge clk);
    op_valid = 1'b0; func_sel = 4'd0; ld_a = 1'b0; ld_b = 1'b0;
    chk("ready_exec", 32'(op_ready), 32'd0);
    chk("fsel_exec", 32'(alu_func_sel), 32'(code));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("skip_pulse", 32'(skip), 32'(exp_skip));
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("ready_idle", 32'(op_ready), 32'd1);
  endtask

  task automatic regs(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                      input logic ec, input logic ez);
    chk({tag, "_a"}, 32'(alu_a), 32'(ea));
    chk({tag, "_b"}, 32'(alu_b), 32'(eb));
    chk({tag, "_c"}, 32'(flag_c), 32'(ec));
    chk({tag, "_z"}, 32'(flag_z), 32'(ez));
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; func_sel = 4'd0; ld_a = 1'b0; ld_b = 1'b0; ld_data = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    regs("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("reset_ready", 32'(op_ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_skip", 32'(skip), 32'd0);
    chk("reset_fsel", 32'(alu_func_sel), 32'd0);

    load(1'b1, 1'b0, 16'h1234);
    do_op(4'd1, 1'b0);
    regs("add", 16'h1234, 16'h0000, 1'b0, 1'b0);

    load(1'b1, 1'b0, 16'hFFFF);
    do_op(4'd10, 1'b0);
    regs("inca_wrap", 16'h0000, 16'h0000, 1'b1, 1'b1);
    do_op(4'd13, 1'b1);
    regs("sz_taken", 16'h0000, 16'h0000, 1'b1, 1'b1);

    load(1'b0, 1'b1, 16'h0000);
    do_op(4'd7, 1'b0);
    regs("decb_borrow", 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    chk("alu_z", 32'(alu_z), 32'd0);
    do_op(4'd8, 1'b0);
    chk("clc", 32'(flag_c), 32'd0);
    do_op(4'd13, 1'b0);

    load(1'b1, 1'b0, 16'h5555);
    ld_b = 1'b1; ld_data = 16'h00F0;
    do_op(4'd5, 1'b0);
    regs("ldb_cmb", 16'h5555, 16'hFF0F, 1'b0, 1'b0);

    do_op(4'd2, 1'b0);
    regs("and", 16'h5505, 16'hFF0F, 1'b0, 1'b0);
    load(1'b1, 1'b0, 16'h8001);
    do_op(4'd15, 1'b0);
    regs("lsh", 16'h0002, 16'hFF0F, 1'b1, 1'b0);
    do_op(4'd3, 1'b0);
    regs("cla", 16'h0000, 16'hFF0F, 1'b1, 1'b1);
    do_op(4'd9, 1'b0);
    chk("clz", 32'(flag_z), 32'd0);
    do_op(4'd4, 1'b0);
    regs("clb", 16'h0000, 16'h0000, 1'b1, 1'b1);
    do_op(4'd0, 1'b0);
    regs("nop", 16'h0000, 16'h0000, 1'b1, 1'b1);

    // op_valid held high: three INCB ops in nine cycles, load during EXEC dropped
    op_valid = 1'b1; func_sel = 4'd6; dn = 0; rd = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin ld_a = 1'b1; ld_data = 16'hAAAA; end
      else ld_a = 1'b0;
      dn += int'(done);
      rd += int'(op_ready);
    end
    op_valid = 1'b0; func_sel = 4'd0;
    chk("b2b_done_count", 32'(dn), 32'd3);
    chk("b2b_ready_count", 32'(rd), 32'd3);
    regs("b2b", 16'h0000, 16'h0003, 1'b0, 1'b0);

    load(1'b1, 1'b0, 16'h7FFF);
    load(1'b0, 1'b1, 16'h0001);
    do_op(4'd1, 1'b0);
    regs("add_ovf", 16'h8000, 16'h0001, 1'b0, 1'b0);
`ifdef ALU_OVF_FLAG_EN
    chk("flag_v_set", 32'(flag_v), 32'd1);
`endif
    do_op(4'd8, 1'b0);
`ifdef ALU_OVF_FLAG_EN
    chk("flag_v_clc", 32'(flag_v), 32'd0);
`endif

    load(1'b1, 1'b0, 16'hFFFF);
    do_op(4'd10, 1'b0);
    regs("pre_abort", 16'h0000, 16'h0001, 1'b1, 1'b1);
    load(1'b1, 1'b0, 16'h0005);
    op_valid = 1'b1; func_sel = 4'd1;
    @(negedge clk);
    op_valid = 1'b0; func_sel = 4'd0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    regs("abort", 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    chk("abort_no_late_done", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
